// File: rtl/sass_key_conditioner_if.sv
// sass_key_conditioner_if: bundles the raw breakout-board inputs and the
// conditioned outputs that feed sass_synth. The conditioner uses the slave
// modport. The master modport is for whatever drives the raw pins, such as a
// pad ring wrapper or a testbench.
interface sass_key_conditioner_if #(
    parameter int NKEYS = 15,
    parameter int NBTN  = 3
);
    logic [NKEYS-1:0] keys_raw;
    logic [NBTN-1:0]  btn_raw;
    logic [NKEYS-1:0] keys_db;
    logic [NKEYS-1:0] key_press;
    logic [NBTN-1:0]  btn_db;
    logic [NBTN-1:0]  btn_press;
    logic [3:0]       key_code;
    logic             key_valid;
    logic             tick;

    modport master (
        output keys_raw, btn_raw,
        input  keys_db, key_press, btn_db, btn_press, key_code, key_valid, tick
    );

    modport slave (
        input  keys_raw, btn_raw,
        output keys_db, key_press, btn_db, btn_press, key_code, key_valid, tick
    );
endinterface

// File: rtl/sass_key_conditioner.sv
// sass_key_conditioner: synchronises, debounces and edge-detects the 15 piano
// keys and 3 control buttons (bit 0 seq_power, bit 1 tempo_select,
// bit 2 seq_play), then priority-encodes the highest pressed key.
//
// Optional build macro KEYCOND_TOGGLE_EN:
//   - When it is defined, each btn_db bit becomes a toggle flop. The flop
//     inverts one cycle after every btn_press pulse, which gives latched
//     power, tempo and play modes.
//   - When it is undefined, btn_db is the plain debounced button level.
//
// Every key and button goes through the same chain, handled as one vector:
//   sync (2 flops) -> tick-sampled history -> accept -> edge -> encoder
module sass_key_conditioner #(
    parameter int NKEYS          = 15,
    parameter int NBTN           = 3,
    parameter int TICK_DIV       = 10000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    sass_key_conditioner_if.slave bus
);
    localparam int NIN = NKEYS + NBTN;
    localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Bit order inside the vector: keys occupy the low bits, buttons the high bits.
    logic [NIN-1:0]                     sync1_q, sync2_q;
    logic [CW-1:0]                      cnt_q, cnt_d;
    logic                               tick;
    logic [NIN-1:0][STABLE_SAMPLES-1:0] hist_q, hist_d;
    logic [NIN-1:0]                     db_q, db_d;
    logic [NIN-1:0]                     db_dly_q;
    logic [NIN-1:0]                     press_q;
    logic [3:0]                         code_q, code_d;
    logic                               valid_q, valid_d;

    // Two-flop synchroniser for every asynchronous input.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.btn_raw, bus.keys_raw};
            sync2_q <= sync1_q;
        end
    end

    // The sample tick fires while the counter holds its last value.
    assign tick = (cnt_q == CNT_LAST);

    // Next count: wrap to 0 after the tick, otherwise count up.
    always_comb begin
        cnt_d = cnt_q + CNT_ONE;
        if (tick) begin
            cnt_d = '0;
        end
    end

    // Tick prescaler.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Shift the newest synchronised sample into the LSB of each history.
    always_comb begin
        hist_d = hist_q;
        for (int i = 0; i < NIN; i++) begin
            hist_d[i] = {hist_q[i][STABLE_SAMPLES-2:0], sync2_q[i]};
        end
    end

    // The sample history advances only on tick, so a glitch between ticks is never seen.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hist_q <= '0;
        end else if (tick) begin
            hist_q <= hist_d;
        end
    end

    // Accept rule: a uniform history sets the level, a mixed history holds it.
    //   - History changes only on tick, so this compare sees each new history for
    //     exactly the cycles until the next tick. That lands the load in the cycle
    //     after the qualifying tick.
    //   - An all-zero history after reset keeps the level at 0, so reset release
    //     never fakes an edge.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NIN; i++) begin
            if (&hist_q[i]) begin
                db_d[i] = 1'b1;
            end else if (~|hist_q[i]) begin
                db_d[i] = 1'b0;
            end
        end
    end

    // Debounced levels, their one-cycle delay, and the registered rising-edge pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            db_q     <= '0;
            db_dly_q <= '0;
            press_q  <= '0;
        end else begin
            db_q     <= db_d;
            db_dly_q <= db_q;
            press_q  <= db_q & ~db_dly_q;
        end
    end

    // Priority encoder: ascending scan, so the highest pressed index wins.
    always_comb begin
        code_d  = '0;
        valid_d = |db_q[NKEYS-1:0];
        for (int i = 0; i < NKEYS; i++) begin
            if (db_q[i]) begin
                code_d = 4'(i);
            end
        end
    end

    // Registered encoder outputs, aligned with key_press.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

`ifdef KEYCOND_TOGGLE_EN
    logic [NBTN-1:0] tog_q;

    // Latched mode bits: each button press flips its mode one cycle after the pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tog_q <= '0;
        end else begin
            tog_q <= tog_q ^ press_q[NIN-1:NKEYS];
        end
    end

    assign bus.btn_db = tog_q;
`else
    assign bus.btn_db = db_q[NIN-1:NKEYS];
`endif

    assign bus.keys_db   = db_q[NKEYS-1:0];
    assign bus.key_press = press_q[NKEYS-1:0];
    assign bus.btn_press = press_q[NIN-1:NKEYS];
    assign bus.key_code  = code_q;
    assign bus.key_valid = valid_q;
    assign bus.tick      = tick;

endmodule
